// File: rtl/multiplier_pipelined_hs.sv
// Two-stage pipelined WIDTH x WIDTH multiplier with valid/ready handshakes on both sides.
// Optional signed mode is enabled by defining MULT_SIGNED_EN (adds the is_signed port).
module multiplier_pipelined_hs #(
  parameter int unsigned WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
`ifdef MULT_SIGNED_EN
  input  logic                 is_signed,
`endif
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [2*WIDTH-1:0]   r
);

  localparam int unsigned HALF = WIDTH / 2;
  localparam int unsigned PW   = 2 * WIDTH;

  if ((WIDTH < 4) || ((WIDTH % 2) != 0)) begin : g_width_check
    $error("multiplier_pipelined_hs: WIDTH must be even and >= 4");
  end

  logic             r_s1_valid;
  logic             r_s1_neg;
  logic [WIDTH-1:0] r_pp_ll;
  logic [WIDTH-1:0] r_pp_hl;
  logic [WIDTH-1:0] r_pp_lh;
  logic [WIDTH-1:0] r_pp_hh;
  logic             r_out_valid;
  logic [PW-1:0]    r_prod;

  logic             w_s2_adv;
  logic             w_s1_adv;
  logic [WIDTH-1:0] w_a_mag;
  logic [WIDTH-1:0] w_b_mag;
  logic             w_neg;
  logic [HALF-1:0]  w_a_lo;
  logic [HALF-1:0]  w_a_hi;
  logic [HALF-1:0]  w_b_lo;
  logic [HALF-1:0]  w_b_hi;
  logic [PW-1:0]    w_sum;
  logic [PW-1:0]    w_res;

  assign w_s2_adv = !r_out_valid || out_ready;
  assign w_s1_adv = !r_s1_valid || w_s2_adv;
  assign in_ready = w_s1_adv;

  // Operand magnitudes; -2^(WIDTH-1) negates to itself, which is the correct unsigned magnitude.
`ifdef MULT_SIGNED_EN
  assign w_a_mag = (is_signed && a[WIDTH-1]) ? (~a + WIDTH'(1)) : a;
  assign w_b_mag = (is_signed && b[WIDTH-1]) ? (~b + WIDTH'(1)) : b;
  assign w_neg   = is_signed && (a[WIDTH-1] ^ b[WIDTH-1]);
`else
  assign w_a_mag = a;
  assign w_b_mag = b;
  assign w_neg   = 1'b0;
`endif

  assign w_a_lo = w_a_mag[HALF-1:0];
  assign w_a_hi = w_a_mag[WIDTH-1:HALF];
  assign w_b_lo = w_b_mag[HALF-1:0];
  assign w_b_hi = w_b_mag[WIDTH-1:HALF];

  assign w_sum = (PW'(r_pp_hh) << WIDTH)
               + PW'(r_pp_ll)
               + (PW'(r_pp_hl) << HALF)
               + (PW'(r_pp_lh) << HALF);
  assign w_res = r_s1_neg ? (~w_sum + PW'(1)) : w_sum;

  // Stage 1 holds partial products; stage 2 holds the summed result.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_s1_valid  <= 1'b0;
      r_s1_neg    <= 1'b0;
      r_pp_ll     <= '0;
      r_pp_hl     <= '0;
      r_pp_lh     <= '0;
      r_pp_hh     <= '0;
      r_out_valid <= 1'b0;
      r_prod      <= '0;
    end else begin
      if (w_s1_adv) begin
        r_s1_valid <= in_valid;
        if (in_valid) begin
          r_pp_ll  <= WIDTH'(w_a_lo) * WIDTH'(w_b_lo);
          r_pp_hl  <= WIDTH'(w_a_hi) * WIDTH'(w_b_lo);
          r_pp_lh  <= WIDTH'(w_a_lo) * WIDTH'(w_b_hi);
          r_pp_hh  <= WIDTH'(w_a_hi) * WIDTH'(w_b_hi);
          r_s1_neg <= w_neg;
        end
      end
      if (w_s2_adv) begin
        r_out_valid <= r_s1_valid;
        if (r_s1_valid) begin
          r_prod <= w_res;
        end
      end
    end
  end

  assign out_valid = r_out_valid;
  assign r         = r_prod;

endmodule

// File: tb/tb_multiplier_pipelined_hs.sv
// Directed self-checking bench for multiplier_pipelined_hs (WIDTH=32); signed steps need MULT_SIGNED_EN.
module tb_multiplier_pipelined_hs;

  localparam int unsigned W = 32;

  logic           clk;
  logic           reset;
  logic           in_valid;
  logic           in_ready;
  logic [W-1:0]   a;
  logic [W-1:0]   b;
`ifdef MULT_SIGNED_EN
  logic           is_signed;
`endif
  logic           out_valid;
  logic           out_ready;
  logic [2*W-1:0] r;

  int n_pass  = 0;
  int n_fail  = 0;
  int n_total = 0;

  logic [2*W-1:0] exp_q[$];
  logic [2*W-1:0] exp_v;
  int             n_out;

  multiplier_pipelined_hs #(.WIDTH(W)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
`ifdef MULT_SIGNED_EN
    .is_signed (is_signed),
`endif
    .out_valid (out_valid),
    .out_ready (out_ready),
    .r         (r)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] expv);
    n_total++;
    assert (obs === expv) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, expv);
    end
  endtask

  // Advance one clock edge and settle just after it.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset     = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    a         = '0;
    b         = '0;
`ifdef MULT_SIGNED_EN
    is_signed = 1'b0;
`endif
    cyc();
    cyc();
    chk("rst_out_valid", 128'(out_valid), 128'(0));
    chk("rst_r",         128'(r),         128'(0));
    chk("rst_in_ready",  128'(in_ready),  128'(1));
    reset = 1'b0;

    // Unsigned latency: max x max
    in_valid = 1'b1; a = 32'hFFFF_FFFF; b = 32'hFFFF_FFFF;
    cyc();
    in_valid = 1'b0;
    chk("lat_e1_out_valid", 128'(out_valid), 128'(0));
    cyc();
    chk("lat_e2_out_valid", 128'(out_valid), 128'(1));
    chk("lat_e2_r",         128'(r),         128'(64'hFFFF_FFFE_0000_0001));
    cyc();
    chk("lat_e3_out_valid", 128'(out_valid), 128'(0));
    chk("lat_e3_r_hold",    128'(r),         128'(64'hFFFF_FFFE_0000_0001));

    // Bubbles: 3*7, gap, 0x10000*0x10000
    in_valid = 1'b1; a = 32'd3; b = 32'd7;
    cyc();
    in_valid = 1'b0;
    cyc();
    chk("bub_r21_valid", 128'(out_valid), 128'(1));
    chk("bub_r21",       128'(r),         128'(21));
    in_valid = 1'b1; a = 32'h0001_0000; b = 32'h0001_0000;
    cyc();
    in_valid = 1'b0;
    chk("bub_gap_valid", 128'(out_valid), 128'(0));
    chk("bub_gap_r",     128'(r),         128'(21));
    cyc();
    chk("bub_big_valid", 128'(out_valid), 128'(1));
    chk("bub_big_r",     128'(r),         128'(64'h1_0000_0000));
    cyc();

    // Backpressure: 2*3, 4*5, 6*7 with consumer stalled 5 cycles
    out_ready = 1'b0;
    in_valid = 1'b1; a = 32'd2; b = 32'd3;
    #1 chk("bp_rdy0", 128'(in_ready), 128'(1));
    cyc();
    a = 32'd4; b = 32'd5;
    chk("bp_rdy1", 128'(in_ready), 128'(1));
    cyc();
    a = 32'd6; b = 32'd7;
    chk("bp_rdy2_low", 128'(in_ready),  128'(0));
    chk("bp_valid2",   128'(out_valid), 128'(1));
    chk("bp_r2",       128'(r),         128'(6));
    for (int i = 0; i < 3; i++) begin
      cyc();
      chk("bp_stall_rdy",   128'(in_ready),  128'(0));
      chk("bp_stall_valid", 128'(out_valid), 128'(1));
      chk("bp_stall_r",     128'(r),         128'(6));
    end
    out_ready = 1'b1;
    #1 chk("bp_release_rdy", 128'(in_ready), 128'(1));
    cyc();
    in_valid = 1'b0;
    chk("bp_r_20_valid", 128'(out_valid), 128'(1));
    chk("bp_r_20",       128'(r),         128'(20));
    cyc();
    chk("bp_r_42_valid", 128'(out_valid), 128'(1));
    chk("bp_r_42",       128'(r),         128'(42));
    cyc();
    chk("bp_drained", 128'(out_valid), 128'(0));

    // Streaming: 100 back-to-back random ops
    n_out = 0;
    for (int i = 0; i < 102; i++) begin
      if (i < 100) begin
        in_valid = 1'b1;
        a = $urandom();
        b = $urandom();
        exp_q.push_back(64'(a) * 64'(b));
        #1 chk("str_in_ready", 128'(in_ready), 128'(1));
      end else begin
        in_valid = 1'b0;
      end
      cyc();
      if (out_valid) begin
        if (exp_q.size() == 0) begin
          chk("str_extra_result", 128'(r), 128'(0) - 128'(1));
        end else begin
          exp_v = exp_q.pop_front();
          chk("str_result", 128'(r), 128'(exp_v));
          n_out++;
        end
      end
    end
    chk("str_count", 128'(n_out), 128'(100));
    cyc();
    chk("str_idle", 128'(out_valid), 128'(0));

    // Reset mid-stream with two ops in flight: 9*9 and 11*11 are discarded
    out_ready = 1'b0;
    in_valid = 1'b1; a = 32'd9; b = 32'd9;
    cyc();
    a = 32'd11; b = 32'd11;
    cyc();
    chk("rst2_full_rdy", 128'(in_ready), 128'(0));
    in_valid = 1'b0;
    reset = 1'b1;
    cyc();
    chk("rst2_out_valid", 128'(out_valid), 128'(0));
    chk("rst2_r",         128'(r),         128'(0));
    cyc();
    reset = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      cyc();
      chk("rst2_no_ghost", 128'(out_valid), 128'(0));
    end

`ifdef MULT_SIGNED_EN
    // Signed mode
    in_valid = 1'b1; is_signed = 1'b1; a = 32'hFFFF_FFFF; b = 32'd5;
    cyc();
    a = 32'h8000_0000; b = 32'h8000_0000;
    cyc();
    chk("sgn_m1x5", 128'(r), 128'(64'hFFFF_FFFF_FFFF_FFFB));
    is_signed = 1'b0; a = 32'hFFFF_FFFF; b = 32'd5;
    cyc();
    in_valid = 1'b0;
    chk("sgn_min_sq", 128'(r), 128'(64'h4000_0000_0000_0000));
    cyc();
    chk("uns_ffx5", 128'(r), 128'(64'h0000_0004_FFFF_FFFB));
    cyc();
`endif

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
